// File: rtl/sdram_line_sequencer.sv
// Sequences 8-word line fetches and write-backs onto a single-command SDRAM
// controller port, interleaving periodic auto-refresh between requests.
module sdram_line_sequencer #(
  parameter int READ_LATENCY     = 4,
  parameter int ACT_GAP          = 3,
  parameter int WR_RECOVERY      = 4,
  parameter int REFRESH_INTERVAL = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [20:0]  req_addr,
  input  logic [255:0] req_wr_data,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic [255:0] rsp_rd_data,
  input  logic         sdrc_init_done,
  input  logic         sdrc_cmd_ack,
  output logic         sdrc_cmd_en,
  output logic [2:0]   sdrc_cmd,
  output logic         sdrc_precharge_ctrl,
  output logic [20:0]  sdrc_addr,
  output logic [3:0]   sdrc_dqm,
  output logic [31:0]  sdrc_wr_data,
  output logic [7:0]   sdrc_data_len,
  input  logic [31:0]  sdrc_rd_data
);

  localparam logic [3:0] S_INIT     = 4'd0;
  localparam logic [3:0] S_IDLE     = 4'd1;
  localparam logic [3:0] S_REF      = 4'd2;
  localparam logic [3:0] S_REF_WAIT = 4'd3;
  localparam logic [3:0] S_ACT      = 4'd4;
  localparam logic [3:0] S_ACT_GAP  = 4'd5;
  localparam logic [3:0] S_WR       = 4'd6;
  localparam logic [3:0] S_WR_WAIT  = 4'd7;
  localparam logic [3:0] S_RD       = 4'd8;
  localparam logic [3:0] S_RD_LAT   = 4'd9;
  localparam logic [3:0] S_RD_CAP   = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b101;

  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_INTERVAL - 1);
  // ACT_GAP and WR_RECOVERY are assumed to be at least 1.
  localparam logic [7:0] GAP_LAST = 8'(ACT_GAP - 1);
  localparam logic [7:0] LAT_LAST = 8'(READ_LATENCY - 2);
  localparam logic [7:0] REC_LAST = 8'(WR_RECOVERY - 1);

  logic [3:0]    state, state_n;
  logic [7:0]    step, step_n;
  logic [CW-1:0] ref_cnt, ref_cnt_n;
  logic          ref_pend, ref_pend_n;
  logic          ack_seen, ack_seen_n;
  logic          accept;
  logic          line_write;
  logic [20:0]   line_addr, line_addr_n;
  logic [255:0]  line_wdata;
  logic [255:0]  cap_line;

  always_comb begin
    state_n    = state;
    step_n     = step;
    ref_pend_n = ref_pend;
    ack_seen_n = 1'b0;
    accept     = 1'b0;

    if (state == S_INIT)
      ref_cnt_n = '0;
    else if (ref_cnt == REF_LAST)
      ref_cnt_n = '0;
    else
      ref_cnt_n = ref_cnt + 1'b1;

    case (state)
      S_INIT:     if (sdrc_init_done) state_n = S_REF;
      S_IDLE: begin
        if (ref_pend) begin
          state_n = S_REF;
        end else if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_n = S_ACT;
        end
      end
      S_REF:      state_n = S_REF_WAIT;
      S_REF_WAIT: begin
        if (sdrc_cmd_ack) begin
          state_n    = S_IDLE;
          ref_pend_n = 1'b0;
        end
      end
      S_ACT: begin
        state_n = S_ACT_GAP;
        step_n  = '0;
      end
      S_ACT_GAP: begin
        if (step >= GAP_LAST) begin
          state_n = line_write ? S_WR : S_RD;
          step_n  = '0;
        end else begin
          step_n = step + 1'b1;
        end
      end
      // The write acknowledge may land during the burst, so it is remembered.
      S_WR: begin
        ack_seen_n = ack_seen | sdrc_cmd_ack;
        if (step == 8'd7) begin
          state_n = S_WR_WAIT;
          step_n  = '0;
        end else begin
          step_n = step + 1'b1;
        end
      end
      S_WR_WAIT: begin
        ack_seen_n = ack_seen | sdrc_cmd_ack;
        if (step >= REC_LAST) begin
          if (ack_seen_n) state_n = S_DONE;
        end else begin
          step_n = step + 1'b1;
        end
      end
      S_RD: begin
        state_n = (READ_LATENCY > 1) ? S_RD_LAT : S_RD_CAP;
        step_n  = '0;
      end
      S_RD_LAT: begin
        if (step >= LAT_LAST) begin
          state_n = S_RD_CAP;
          step_n  = '0;
        end else begin
          step_n = step + 1'b1;
        end
      end
      S_RD_CAP: begin
        if (step == 8'd7) state_n = S_DONE;
        else              step_n  = step + 1'b1;
      end
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_INIT;
    endcase

    if (state != S_INIT && ref_cnt == REF_LAST) ref_pend_n = 1'b1;

    line_addr_n = accept ? (req_addr & ~21'h7) : line_addr;
  end

  // Outputs are registered from the next-state values so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_INIT;
      step                <= '0;
      ref_cnt             <= '0;
      ref_pend            <= 1'b0;
      ack_seen            <= 1'b0;
      line_write          <= 1'b0;
      line_addr           <= '0;
      line_wdata          <= '0;
      cap_line            <= '0;
      req_ready           <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_rd_data         <= '0;
      sdrc_cmd_en         <= 1'b0;
      sdrc_cmd            <= '0;
      sdrc_addr           <= '0;
      sdrc_wr_data        <= '0;
      sdrc_precharge_ctrl <= 1'b1;
      sdrc_dqm            <= 4'h0;
      sdrc_data_len       <= 8'd7;
    end else begin
      state    <= state_n;
      step     <= step_n;
      ref_cnt  <= ref_cnt_n;
      ref_pend <= ref_pend_n;
      ack_seen <= ack_seen_n;
      line_addr <= line_addr_n;
      if (accept) begin
        line_write <= req_write;
        line_wdata <= req_wr_data;
      end
      if (state == S_RD_CAP)
        cap_line[{step[2:0], 5'b00000} +: 32] <= sdrc_rd_data;
      if (state == S_RD_CAP && step == 8'd7)
        rsp_rd_data <= {sdrc_rd_data, cap_line[223:0]};

      req_ready           <= (state_n == S_IDLE) && !ref_pend_n;
      rsp_valid           <= (state_n == S_DONE);
      sdrc_precharge_ctrl <= 1'b1;
      sdrc_dqm            <= 4'h0;
      sdrc_data_len       <= 8'd7;

      sdrc_cmd_en  <= 1'b0;
      sdrc_cmd     <= '0;
      sdrc_addr    <= '0;
      sdrc_wr_data <= '0;
      case (state_n)
        S_REF: begin
          sdrc_cmd_en <= 1'b1;
          sdrc_cmd    <= CMD_REF;
        end
        S_ACT: begin
          sdrc_cmd_en <= 1'b1;
          sdrc_cmd    <= CMD_ACT;
          sdrc_addr   <= {line_addr_n[20:8], 8'h00};
        end
        S_WR: begin
          sdrc_wr_data <= line_wdata[{step_n[2:0], 5'b00000} +: 32];
          if (step_n == 8'd0) begin
            sdrc_cmd_en <= 1'b1;
            sdrc_cmd    <= CMD_WRITE;
            sdrc_addr   <= line_addr;
          end
        end
        S_RD: begin
          sdrc_cmd_en <= 1'b1;
          sdrc_cmd    <= CMD_READ;
          sdrc_addr   <= line_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_line_sequencer.sv
// Scoreboard bench: a behavioural SDRAM/controller model answers commands, a
// reference line memory predicts every response and command address.
module tb_sdram_line_sequencer;

  localparam int RL  = 4;
  localparam int AG  = 3;
  localparam int WRR = 4;
  localparam int RI  = 120;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [20:0]  req_addr = '0;
  logic [255:0] req_wr_data = '0;
  logic         req_ready;
  logic         rsp_valid;
  logic [255:0] rsp_rd_data;
  logic         sdrc_init_done = 1'b0;
  logic         sdrc_cmd_ack = 1'b0;
  logic         sdrc_cmd_en;
  logic [2:0]   sdrc_cmd;
  logic         sdrc_precharge_ctrl;
  logic [20:0]  sdrc_addr;
  logic [3:0]   sdrc_dqm;
  logic [31:0]  sdrc_wr_data;
  logic [7:0]   sdrc_data_len;
  logic [31:0]  sdrc_rd_data = '0;

  sdram_line_sequencer #(
    .READ_LATENCY(RL), .ACT_GAP(AG), .WR_RECOVERY(WRR), .REFRESH_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .sdrc_init_done(sdrc_init_done), .sdrc_cmd_ack(sdrc_cmd_ack),
    .sdrc_cmd_en(sdrc_cmd_en), .sdrc_cmd(sdrc_cmd),
    .sdrc_precharge_ctrl(sdrc_precharge_ctrl), .sdrc_addr(sdrc_addr),
    .sdrc_dqm(sdrc_dqm), .sdrc_wr_data(sdrc_wr_data),
    .sdrc_data_len(sdrc_data_len), .sdrc_rd_data(sdrc_rd_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]  ref_mem  [int];
  logic [31:0]  dram_mem [int];
  logic [255:0] exp_rsp  [$];
  logic [23:0]  exp_cmd  [$];
  logic [255:0] last_line = '0;

  int cyc = 0;
  int ref_count = 0;
  int last_ref_cyc = -1;
  int ack_cyc = -1;
  int wr_start = -100;
  int rd_start = -100;
  logic [20:0] wr_addr = '0;
  logic [20:0] rd_addr = '0;
  logic prev_en = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Unwritten SDRAM locations hold a fixed, address-derived pattern.
  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3A50F0F;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] dram_word(input int a);
    if (dram_mem.exists(a)) return dram_mem[a];
    return init_word(a);
  endfunction

  // SDRAM + controller model: checks commands, acks them, stores and returns bursts.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ack_cyc      = -1;
      wr_start     = -100;
      rd_start     = -100;
      prev_en      = 1'b0;
      sdrc_cmd_ack = 1'b0;
    end else begin
      if (sdrc_cmd_en) begin
        checkOutput("cmd_en_back_to_back", prev_en, 1'b0);
        checkOutput("fixed_outputs", {sdrc_precharge_ctrl, sdrc_dqm, sdrc_data_len}, 13'h1007);
        checkOutput("cmd_after_init_done", sdrc_init_done, 1'b1);
        if (sdrc_cmd == 3'b001) begin
          ref_count++;
          if (last_ref_cyc >= 0)
            checkOutput("refresh_gap_in_window",
                        ((cyc - last_ref_cyc) >= RI - 40) && ((cyc - last_ref_cyc) <= RI + 40), 1'b1);
          last_ref_cyc = cyc;
          ack_cyc = cyc + int'($urandom_range(1, 3));
        end else begin
          if (exp_cmd.size() == 0)
            checkOutput("unexpected_cmd", {sdrc_cmd, sdrc_addr}, 24'h0);
          else
            checkOutput("cmd_and_addr", {sdrc_cmd, sdrc_addr}, exp_cmd.pop_front());
          if (sdrc_cmd == 3'b100) begin
            wr_start = cyc;
            wr_addr  = sdrc_addr;
            ack_cyc  = cyc + int'($urandom_range(1, 16));
          end else if (sdrc_cmd == 3'b101) begin
            rd_start = cyc + RL;
            rd_addr  = sdrc_addr;
            ack_cyc  = cyc + 1;
          end else begin
            ack_cyc = cyc + int'($urandom_range(1, 2));
          end
        end
      end
      prev_en = sdrc_cmd_en;
      sdrc_cmd_ack = (cyc == ack_cyc);
      if (cyc >= wr_start && cyc < wr_start + 8)
        dram_mem[int'(wr_addr) + (cyc - wr_start)] = sdrc_wr_data;
      if (cyc >= rd_start && cyc < rd_start + 8)
        sdrc_rd_data = dram_word(int'(rd_addr) + (cyc - rd_start));
      else
        sdrc_rd_data = $urandom;
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_rsp.size() == 0)
        checkOutput("unexpected_rsp_valid", rsp_valid, 1'b0);
      else
        checkOutput("rsp_rd_data", rsp_rd_data, exp_rsp.pop_front());
    end
  end

  task automatic applyStimulus(input logic wr, input logic [20:0] addr, input logic [255:0] data);
    int base;
    int n;
    logic [255:0] line;
    base = int'(addr) & ~7;
    exp_cmd.push_back({3'b011, addr[20:8], 8'h00});
    exp_cmd.push_back({wr ? 3'b100 : 3'b101, 21'(base)});
    if (wr) begin
      for (int i = 0; i < 8; i++) ref_mem[base + i] = data[i*32 +: 32];
      exp_rsp.push_back(last_line);
    end else begin
      for (int i = 0; i < 8; i++) line[i*32 +: 32] = model_word(base + i);
      last_line = line;
      exp_rsp.push_back(line);
    end
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wr_data = data;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_accepted", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 21'($urandom);
    for (int i = 0; i < 8; i++) req_wr_data[i*32 +: 32] = $urandom;
  endtask

  task automatic doInit();
    int n;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("ready_low_before_init_done", req_ready, 1'b0);
    sdrc_init_done = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_after_init", req_ready, 1'b1);
    checkOutput("init_refresh_count", ref_count, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("responses_drained", exp_rsp.size(), 0);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [255:0] line0, line1;
    logic [20:0]  a;
    int n;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {sdrc_cmd_en, sdrc_cmd, sdrc_addr, sdrc_wr_data, req_ready, rsp_valid}, '0);
    checkOutput("reset_rsp_rd_data", rsp_rd_data, '0);
    doInit();

    line0[31:0]  = 32'h12345678;
    line0[63:32] = 32'habcdef01;
    for (int i = 2; i < 8; i++) line0[i*32 +: 32] = 32'h01020304 * 32'(i);
    line1 = rand_line();
    line1[31:0] = 32'h10102020;

    applyStimulus(1'b1, 21'h000000, line0);
    drain();
    applyStimulus(1'b0, 21'h000000, rand_line());
    drain();
    applyStimulus(1'b1, 21'h000100, line1);
    applyStimulus(1'b0, 21'h000100, rand_line());
    applyStimulus(1'b0, 21'h000000, rand_line());
    applyStimulus(1'b0, 21'h000105, rand_line());
    drain();

    for (int k = 0; k < 60; k++) begin
      a = {2'($urandom), 9'h000, 2'($urandom), 8'($urandom)};
      applyStimulus(1'($urandom), a, rand_line());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    applyStimulus(1'b0, 21'h000100, rand_line());
    n = 0;
    while (!(cyc >= rd_start + 2 && cyc <= rd_start + 5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_read_capture", n < 100, 1'b1);
    rst = 1'b1;
    sdrc_init_done = 1'b0;
    exp_rsp.delete();
    exp_cmd.delete();
    last_line = '0;
    @(negedge clk);
    checkOutput("midread_reset_cmd_en", sdrc_cmd_en, 1'b0);
    checkOutput("midread_reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midread_reset_req_ready", req_ready, 1'b0);
    checkOutput("midread_reset_rsp_rd_data", rsp_rd_data, '0);
    repeat (4) @(negedge clk);
    ref_count = 0;
    last_ref_cyc = -1;
    doInit();
    applyStimulus(1'b0, 21'h000000, rand_line());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, miscompares=%0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
